// File: rtl/instr_fetch.sv
// instr_fetch: front-end fetch stage.
// Holds the fetch PC and issues word reads over a request/grant interface.
// Returned words are paired with their PCs and queued for decode.
// Branch and jump redirects drop every fetch that is in flight or buffered.
//
// Handshakes, valid/ready semantics:
//   - imem request side: an issue happens on a cycle where w_imem_req and
//     w_imem_gnt are both high. While req is high and gnt is low, req and addr
//     stay stable.
//   - imem response side: w_imem_rvalid has no backpressure. Responses come
//     back in issue order.
//   - decode side: a transfer happens on a cycle where w_instr_valid and
//     w_instr_ready are both high. While valid is high and ready is low,
//     instr and pc stay stable.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8002_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        w_clk,
  input  logic        w_rst_n,
  output logic        w_imem_req,
  output logic [31:0] w_imem_addr_32,
  input  logic        w_imem_gnt,
  input  logic        w_imem_rvalid,
  input  logic [31:0] w_imem_rdata_32,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc_32,
  output logic        w_instr_valid,
  input  logic        w_instr_ready,
  output logic [31:0] w_instr_out_32,
  output logic [31:0] w_pc_32,
  output logic [1:0]  w_dbg_state_2
);

  // Counter width holds 0..DEPTH. Pointer width indexes DEPTH entries.
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam int             PW      = $clog2(DEPTH);
  localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   buf_cnt_q, buf_cnt_d;
  logic [31:0]     pcq_mem_q [DEPTH];
  logic [31:0]     pcq_mem_d [DEPTH];
  logic [PW-1:0]   pcq_wr_q, pcq_wr_d;
  logic [PW-1:0]   pcq_rd_q, pcq_rd_d;
  logic [31:0]     fifo_data_q [DEPTH];
  logic [31:0]     fifo_data_d [DEPTH];
  logic [31:0]     fifo_pc_q [DEPTH];
  logic [31:0]     fifo_pc_d [DEPTH];

  logic            issue;
  logic            resp;
  logic            resp_keep;
  logic            pop;
  logic [CW:0]     occ;
  logic [CW-1:0]   wr_idx;
  logic [31:0]     resp_pc;

  // Event decode and outputs. A slot freed by this cycle's decode pop can be
  // refilled in the same cycle, which keeps the stream at one word per cycle.
  always_comb begin
    w_instr_valid  = (buf_cnt_q != '0);
    pop            = w_instr_valid & w_instr_ready;
    occ            = {1'b0, inflight_q} + {1'b0, buf_cnt_q} - {{CW{1'b0}}, pop};
    w_imem_req     = (state_q != S_IDLE) && (occ < DEPTH_C);
    w_imem_addr_32 = pc_q;
    issue          = w_imem_req & w_imem_gnt;
    // A response with nothing outstanding is a protocol error, so it is ignored.
    resp           = w_imem_rvalid & (inflight_q != '0);
    resp_keep      = resp & (discard_q == '0) & ~w_redirect;
    resp_pc        = pcq_mem_q[pcq_rd_q];
    w_instr_out_32 = fifo_data_q[0];
    w_pc_32        = fifo_pc_q[0];
    w_dbg_state_2  = state_q;
  end

  // Fetch PC and the queue of issued PCs awaiting their responses.
  always_comb begin
    pc_d      = pc_q;
    pcq_mem_d = pcq_mem_q;
    pcq_wr_d  = pcq_wr_q;
    pcq_rd_d  = pcq_rd_q;
    if (issue) begin
      pcq_mem_d[pcq_wr_q] = pc_q;
      pcq_wr_d            = pcq_wr_q + PW'(1);
      pc_d                = pc_q + 32'd4;
    end
    if (resp) begin
      pcq_rd_d = pcq_rd_q + PW'(1);
    end
    // The redirect-cycle issue still used the old PC. The new target applies
    // from the next cycle.
    if (w_redirect) begin
      pc_d = w_redirect_pc_32 & ~32'h3;
    end
  end

  // In-flight, discard and buffered counters.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !resp) begin
      inflight_d = inflight_q + CW'(1);
    end else if (resp && !issue) begin
      inflight_d = inflight_q - CW'(1);
    end

    discard_d = discard_q;
    if (resp && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
    // Every fetch still outstanding after this cycle belongs to the old path.
    if (w_redirect) begin
      discard_d = inflight_d;
    end

    buf_cnt_d = buf_cnt_q + {{(CW-1){1'b0}}, resp_keep} - {{(CW-1){1'b0}}, pop};
    if (w_redirect) begin
      buf_cnt_d = '0;
    end
  end

  // Output FIFO as a shift queue, so entry 0 is always the registered head.
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    wr_idx      = buf_cnt_q - {{(CW-1){1'b0}}, pop};
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        fifo_data_d[i] = fifo_data_q[i+1];
        fifo_pc_d[i]   = fifo_pc_q[i+1];
      end
    end
    if (resp_keep) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CW'(i) == wr_idx) begin
          fifo_data_d[i] = w_imem_rdata_32;
          fifo_pc_d[i]   = resp_pc;
        end
      end
    end
  end

  // Next-state logic: leave IDLE once after reset. Stay in FLUSH while stale responses remain.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (w_redirect && (discard_d != '0)) state_d = S_FLUSH;
      S_FLUSH: if (discard_d == '0) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
      buf_cnt_q  <= '0;
      pcq_wr_q   <= '0;
      pcq_rd_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pcq_mem_q[i]   <= '0;
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      discard_q   <= discard_d;
      buf_cnt_q   <= buf_cnt_d;
      pcq_wr_q    <= pcq_wr_d;
      pcq_rd_q    <= pcq_rd_d;
      pcq_mem_q   <= pcq_mem_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: bench for instr_fetch.
// The bench models instruction memory as a queue of outstanding fetches.
// The expected decode stream is a queue of {data, pc} words.
// Redirects advance an epoch tag. Only words fetched in the current epoch
// are expected to reach decode.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h8002_0000;
  localparam int          DEPTH    = 2;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [1:0]  dbg;

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .w_clk            (clk),
    .w_rst_n          (rst_n),
    .w_imem_req       (req),
    .w_imem_addr_32   (addr),
    .w_imem_gnt       (gnt),
    .w_imem_rvalid    (rvalid),
    .w_imem_rdata_32  (rdata),
    .w_redirect       (redirect),
    .w_redirect_pc_32 (redirect_pc),
    .w_instr_valid    (valid),
    .w_instr_ready    (ready),
    .w_instr_out_32   (instr),
    .w_pc_32          (pc),
    .w_dbg_state_2    (dbg)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    int          due;
    int          epoch;
  } mem_ent_t;

  // scoreboard state
  mem_ent_t    mem_q[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rel_cyc = 0;
  int          last_due = 0;
  int          epoch = 0;
  int          lat = 1;
  int          iss_cnt = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          hold_rst = 1'b1;
  bit          spur_en = 1'b0;
  bit          fixed_data = 1'b1;
  bit          last_iss = 1'b0;
  bit          last_resp = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_clear();
    mem_q.delete();
    exp_q.delete();
    exp_pc   = RESET_PC;
    last_due = 0;
    iss_cnt  = 0;
  endfunction

  // One clock cycle. Drive inputs 1ns after the rising edge.
  // At the falling edge, compare the DUT against the model.
  // Then apply the events that the next rising edge commits.
  task automatic step(input bit g, input bit r, input bit redir, input logic [31:0] tgt);
    mem_ent_t    e;
    bit          pop;
    bit          exp_req;
    bit          running;
    logic [63:0] head;
    int          occ;
    int          l;
    @(posedge clk);
    #1;
    cyc++;
    if (!hold_rst && !rst_n) begin
      rst_n   = 1'b1;
      rel_cyc = cyc;
    end
    gnt         = g;
    ready       = r;
    redirect    = redir;
    redirect_pc = tgt;
    rvalid      = 1'b0;
    rdata       = $urandom;
    if (mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        rvalid = 1'b1;
        rdata  = mem_q[0].data;
      end
    end else if (spur_en && ($urandom_range(0, 7) == 0)) begin
      rvalid = 1'b1;
    end
    #4;
    last_iss  = 1'b0;
    last_resp = 1'b0;
    if (!rst_n) begin
      chk("rst_req",   32'(req),   32'h0);
      chk("rst_valid", 32'(valid), 32'h0);
      chk("rst_instr", instr,      32'h0);
      chk("rst_pc",    pc,         32'h0);
      chk("rst_state", 32'(dbg),   32'h0);
      return;
    end
    running = (cyc > rel_cyc);
    pop     = (exp_q.size() > 0) && r;
    chk("instr_valid", 32'(valid), 32'(exp_q.size() != 0));
    if (exp_q.size() > 0) begin
      head = exp_q[0];
      chk("instr_out", instr, head[63:32]);
      chk("pc_out",    pc,    head[31:0]);
    end
    occ     = mem_q.size() + exp_q.size() - int'(pop);
    exp_req = running && (occ < DEPTH);
    chk("imem_req", 32'(req), 32'(exp_req));
    if (exp_req) chk("imem_addr", addr, exp_pc);
    // commit this cycle's events in model order: pop, response, issue, redirect
    if (pop) void'(exp_q.pop_front());
    if (rvalid && (mem_q.size() > 0)) begin
      e         = mem_q.pop_front();
      last_resp = 1'b1;
      if ((e.epoch == epoch) && !redir) exp_q.push_back({e.data, e.addr});
    end
    if (exp_req && g) begin
      l       = (lat == 0) ? int'($urandom_range(1, 3)) : lat;
      e.addr  = exp_pc;
      e.data  = fixed_data ? (32'h2000_0000 + 32'(iss_cnt)) : $urandom;
      e.due   = cyc + l;
      if (e.due <= last_due) e.due = last_due + 1;
      last_due = e.due;
      e.epoch  = epoch;
      mem_q.push_back(e);
      iss_cnt++;
      exp_pc   = exp_pc + 32'd4;
      last_iss = 1'b1;
    end
    if (redir) begin
      epoch++;
      exp_q.delete();
      exp_pc = tgt & ~32'h3;
    end
  endtask

  task automatic mid_reset();
    #2;
    rst_n    = 1'b0;
    hold_rst = 1'b1;
    #1;
    chk("async_req",   32'(req),   32'h0);
    chk("async_valid", 32'(valid), 32'h0);
    chk("async_state", 32'(dbg),   32'h0);
    model_clear();
  endtask

  initial begin
    logic [31:0] a0;
    int          n;
    bit          pred;
    gnt = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    rvalid = 1'b0; rdata = 32'h0;
    model_clear();

    // reset held, then release
    repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
    hold_rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("idle_no_req", 32'(req), 32'h0);
    chk("idle_state",  32'(dbg), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_addr", addr,     32'h8002_0000);
    chk("run_state",  32'(dbg), 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("second_addr", addr, 32'h8002_0004);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_valid", 32'(valid), 32'h1);
    chk("first_pc",    pc,         32'h8002_0000);
    chk("first_instr", instr,      32'h2000_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("second_pc",    pc,    32'h8002_0004);
    chk("second_instr", instr, 32'h2000_0001);
    repeat (12) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stream_valid", 32'(valid), 32'h1);
    end

    // decode stall fills the window
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req_low", 32'(req), 32'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // grant withheld: address and request must hold
    step(1'b0, 1'b1, 1'b0, 32'h0);
    a0 = addr;
    chk("gnt_hold_req", 32'(req), 32'h1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("gnt_hold_addr", addr, a0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("gnt_resume_addr", addr, a0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);

    // redirect with two fetches in flight, latency 3
    fixed_data = 1'b0;
    lat = 3;
    n = 0;
    while ((mem_q.size() != 2) && (n < 20)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("wait_two_inflight", 32'(n < 20), 32'h1);
    step(1'b1, 1'b1, 1'b1, 32'h8002_0103);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("flush_state", 32'(dbg),   32'h2);
    chk("flush_valid", 32'(valid), 32'h0);
    n = 0;
    while (!req && (n < 20)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("redir_addr", addr, 32'h8002_0100);
    n = 0;
    while (!valid && (n < 30)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("redir_first_pc", pc, 32'h8002_0100);

    // redirect coinciding with a grant and a response
    lat = 1;
    repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0);
    n = 0;
    pred = 1'b0;
    while (!pred && (n < 20)) begin
      pred = (mem_q.size() > 0) && (mem_q[0].due <= cyc + 1) &&
             ((mem_q.size() + exp_q.size() - int'(exp_q.size() > 0)) < DEPTH);
      if (!pred) step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    step(1'b1, 1'b1, 1'b1, 32'h8002_0200);
    chk("redir_both_events", {30'h0, last_iss, last_resp}, 32'h3);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_fifo_empty", 32'(valid), 32'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    n = 0;
    while (!(req && (addr == 32'hFFFF_FFFC)) && (n < 20)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("wrap_reach", 32'(n < 20), 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    n = 0;
    while (!req && (n < 20)) begin
      step(1'b1, 1'b1, 1'b0, 32'h0);
      n++;
    end
    chk("wrap_addr", addr, 32'h0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);

    // randomized traffic
    spur_en = 1'b1;
    lat = 0;
    repeat (1500) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom);
    end

    // reset in the middle of a stream
    lat = 1;
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0);
    mid_reset();
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    hold_rst = 1'b0;
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_idle_req", 32'(req), 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("restart_req",  32'(req), 32'h1);
    chk("restart_addr", addr,     RESET_PC);
    lat = 0;
    repeat (200) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
Front-end fetch stage that produces the instruction stream consumed by the decode stage. It holds the PC, issues word reads to instruction memory over a request/grant plus response interface, and buffers returned words with their PCs. It delivers them in order over a valid/ready handshake, and supports branch/jump redirects that flush all in-flight and buffered fetches.

Parameters:
RESET_PC, 32'h8002_0000, first fetch address after reset.
DEPTH, 2, max fetches in flight plus buffered (power of 2, 2..8).

Ports:
w_clk  in  1  clock, rising edge.
w_rst_n  in  1  reset, asynchronous, active-low.
w_imem_req  out  1  fetch request valid.
w_imem_addr_32  out  32  fetch word address (bits [1:0] always 0).
w_imem_gnt  in  1  request accepted this cycle (req & gnt = issue).
w_imem_rvalid  in  1  read data valid; responses return in issue order, latency ≥1 cycle.
w_imem_rdata_32  in  32  instruction word.
w_redirect  in  1  redirect pulse from branch/jump resolution.
w_redirect_pc_32  in  32  redirect target; bits [1:0] forced to 0.
w_instr_valid  out  1  instruction available to decode.
w_instr_ready  in  1  decode accepts (low = stall).
w_instr_out_32  out  32  instruction to decode.
w_pc_32  out  32  PC of w_instr_out_32.

Behaviour:
- Reset (async assert): pc_reg = RESET_PC, req = 0, instr_valid = 0, instr_out = 0, pc_out = 0, in-flight count = 0, discard count = 0, buffer empty, state = IDLE.
- States: IDLE → RUN on first clock after reset release. RUN → FLUSH on redirect while responses are in flight. FLUSH → RUN when discard count reaches 0 (or next cycle if it is already 0).
- w_imem_req = 1 in RUN and FLUSH when (inflight + buffered) < DEPTH. w_imem_addr_32 = pc_reg. Addr/req are held stable until gnt.
- Issue (req & gnt): pc_reg += 4, with wrap from 32'hFFFF_FFFC to 0. inflight += 1. Issued PC pushed to a DEPTH-entry PC queue.
- Response (rvalid) with discard = 0: pop PC queue, push {rdata, pc} into DEPTH-entry output FIFO, inflight -= 1.
- Response with discard > 0: pop PC queue and drop the word, discard -= 1, inflight -= 1. Never written to FIFO.
- rvalid when inflight = 0: protocol error, ignored, no state change.
- Output: w_instr_valid = FIFO non-empty. Data and PC are the FIFO head, registered, zero-latency from head. Pop on valid & ready. Held stable while valid & !ready.
- Throughput: one instruction per cycle sustained when gnt and rvalid are continuously high with latency 1 and DEPTH ≥ 2.
- Redirect (highest priority, single cycle):
  - pc_reg = redirect_pc & ~3.
  - Output FIFO cleared; w_instr_valid = 0 the next cycle.
  - discard = inflight after this cycle's issue/response accounting. A request granted in the redirect cycle is discarded; a response arriving in the redirect cycle is dropped.
  - An output handshake (valid & ready) in the redirect cycle counts as delivered.
  - The redirect-cycle request still uses the old address; the new address is presented from the next cycle.
- Redirect while already in FLUSH: discard recomputed per the rule above; pc_reg updated to the latest target.
- Full: when inflight + buffered = DEPTH, req = 0 until a pop or redirect.
- Simultaneous pop, response and issue in one cycle: all three take effect; counts stay consistent.
- Reset mid-operation: all state returns to reset values immediately. Late responses after reset are ignored (inflight = 0).

Test Plan:
- Reset release, gnt = 1, 1-cycle latency, rdata = 32'h2000_0000+k, ready = 1 → addresses 8002_0000, 8002_0004, ...; instr_valid continuous from cycle 3; PCs match addresses.
- ready = 0 for 5 cycles, DEPTH = 2 → req drops after 2 outstanding/buffered; instr_out and pc held; no data lost; order preserved after ready = 1.
- gnt = 0 for 3 cycles → addr held at 8002_0008, req held high; issue resumes with no skipped address.
- Redirect to 32'h8002_0103 with 2 in flight, latency 3 → next addr 8002_0100; both stale responses dropped; first delivered PC = 8002_0100.
- Redirect in same cycle as gnt and rvalid → granted request and arriving response both discarded; FIFO empty next cycle.
- pc_reg = FFFF_FFFC issue → next addr 0000_0000; assert w_rst_n low mid-stream → req = 0, valid = 0 asynchronously; restart at RESET_PC.
